// File: rtl/ysyx_22040210_btb_upd_sched.sv
// BTB update scheduler: coalesces dual-slot commit updates into a small FIFO, drains one
// entry per cycle onto the BTB fix port, and runs the fence.i invalidate sweep.
module ysyx_22040210_btb_upd_sched #(
    parameter int GSH_BTB_NUM = 256,
    parameter int IDX_W       = 8,
    parameter int QDEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd0_valid_i,
    input  logic [63:0]      upd0_pc_i,
    input  logic [63:0]      upd0_target_i,
    input  logic [2:0]       upd0_op_i,
    input  logic             upd1_valid_i,
    input  logic [63:0]      upd1_pc_i,
    input  logic [63:0]      upd1_target_i,
    input  logic [2:0]       upd1_op_i,
    output logic             upd_ready_o,
    input  logic             hold_i,
    input  logic             flush_i,
    output logic             btb_fixwe_o,
    output logic [63:0]      btb_fixpc_o,
    output logic [63:0]      btb_fixjumpaddr_o,
    output logic [2:0]       btb_fixjumpop_o,
    output logic             btb_inv_o,
    output logic [IDX_W-1:0] btb_inv_idx_o,
    output logic             sweep_busy_o,
    output logic             overflow_o
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(GSH_BTB_NUM - 1);

    logic [0:0]       state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic             ovf_q, ovf_d;

    logic [63:0] pc_q  [QDEPTH];
    logic [63:0] pc_d  [QDEPTH];
    logic [63:0] tgt_q [QDEPTH];
    logic [63:0] tgt_d [QDEPTH];
    logic [2:0]  op_q  [QDEPTH];
    logic [2:0]  op_d  [QDEPTH];

    logic             fixwe_q;
    logic [63:0]      fixpc_q;
    logic [63:0]      fixtgt_q;
    logic [2:0]       fixop_q;
    logic [IDX_W-1:0] inv_idx_q;

    logic idle;
    logic deq;
    logic enq_en;
    logic same_pc;

    assign idle    = (state_q == IDLE);
    assign deq     = idle && (cnt_q != '0) && !hold_i && !flush_i;
    assign enq_en  = idle && !flush_i;
    // Both slots naming the same branch collapse into one request carrying slot1's data.
    assign same_pc = upd0_valid_i && upd1_valid_i && (upd0_pc_i == upd1_pc_i);

    always_comb begin
        logic [QDEPTH-1:0] live;
        logic [PTR_W-1:0]  off;
        logic [PTR_W-1:0]  wp;
        logic [CNT_W-1:0]  occ;
        logic              hit;
        logic              rv;
        logic [63:0]       rpc;
        logic [63:0]       rtgt;
        logic [2:0]        rop;

        pc_d  = pc_q;
        tgt_d = tgt_q;
        op_d  = op_q;
        ovf_d = ovf_q;

        // Entries eligible for coalescing: occupied, excluding a head leaving this cycle.
        for (int i = 0; i < QDEPTH; i++) begin
            off     = PTR_W'(i) - rd_q;
            live[i] = ({1'b0, off} < cnt_q) && !(deq && (PTR_W'(i) == rd_q));
        end

        occ = cnt_q - CNT_W'(deq);
        wp  = wr_q;

        for (int r = 0; r < 2; r++) begin
            rv   = (r == 0) ? (upd0_valid_i && !same_pc) : upd1_valid_i;
            rpc  = (r == 0) ? upd0_pc_i     : upd1_pc_i;
            rtgt = (r == 0) ? upd0_target_i : upd1_target_i;
            rop  = (r == 0) ? upd0_op_i     : upd1_op_i;
            hit  = 1'b0;
            if (rv && enq_en) begin
                for (int i = 0; i < QDEPTH; i++) begin
                    if (live[i] && (pc_d[i] == rpc)) begin
                        tgt_d[i] = rtgt;
                        op_d[i]  = rop;
                        hit      = 1'b1;
                    end
                end
                if (!hit) begin
                    if (occ < CNT_W'(QDEPTH)) begin
                        pc_d[wp]  = rpc;
                        tgt_d[wp] = rtgt;
                        op_d[wp]  = rop;
                        live[wp]  = 1'b1;
                        wp        = wp + PTR_W'(1);
                        occ       = occ + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end

        cnt_d = occ;
        wr_d  = wp;
        rd_d  = rd_q + PTR_W'(deq);
        if (flush_i) begin
            cnt_d = '0;
            wr_d  = '0;
            rd_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            ovf_q     <= 1'b0;
            fixwe_q   <= 1'b0;
            fixpc_q   <= '0;
            fixtgt_q  <= '0;
            fixop_q   <= '0;
            inv_idx_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ovf_q   <= ovf_d;
            fixwe_q <= deq;
            if (deq) begin
                fixpc_q  <= pc_q[rd_q];
                fixtgt_q <= tgt_q[rd_q];
                fixop_q  <= op_q[rd_q];
            end
            // Flush restarts the sweep from index 0 regardless of the current state.
            if (flush_i) begin
                state_q   <= SWEEP;
                inv_idx_q <= '0;
            end else if (state_q == SWEEP) begin
                if (inv_idx_q == IDX_LAST) begin
                    state_q <= IDLE;
                end else begin
                    inv_idx_q <= inv_idx_q + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        pc_q  <= pc_d;
        tgt_q <= tgt_d;
        op_q  <= op_d;
    end

    assign upd_ready_o       = idle && (cnt_q <= CNT_W'(QDEPTH - 2));
    assign btb_fixwe_o       = fixwe_q;
    assign btb_fixpc_o       = fixpc_q;
    assign btb_fixjumpaddr_o = fixtgt_q;
    assign btb_fixjumpop_o   = fixop_q;
    assign btb_inv_o         = (state_q == SWEEP);
    assign btb_inv_idx_o     = inv_idx_q;
    assign sweep_busy_o      = (state_q == SWEEP);
    assign overflow_o        = ovf_q;

endmodule

// File: tb/tb_ysyx_22040210_btb_upd_sched.sv
// Bench for the BTB update scheduler: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_ysyx_22040210_btb_upd_sched;

    localparam int N  = 256;
    localparam int QD = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        upd0_valid_i, upd1_valid_i;
    logic [63:0] upd0_pc_i, upd0_target_i, upd1_pc_i, upd1_target_i;
    logic [2:0]  upd0_op_i, upd1_op_i;
    logic        upd_ready_o, hold_i, flush_i;
    logic        btb_fixwe_o;
    logic [63:0] btb_fixpc_o, btb_fixjumpaddr_o;
    logic [2:0]  btb_fixjumpop_o;
    logic        btb_inv_o;
    logic [7:0]  btb_inv_idx_o;
    logic        sweep_busy_o, overflow_o;

    ysyx_22040210_btb_upd_sched #(.GSH_BTB_NUM(N), .IDX_W(8), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .upd0_valid_i(upd0_valid_i), .upd0_pc_i(upd0_pc_i),
        .upd0_target_i(upd0_target_i), .upd0_op_i(upd0_op_i),
        .upd1_valid_i(upd1_valid_i), .upd1_pc_i(upd1_pc_i),
        .upd1_target_i(upd1_target_i), .upd1_op_i(upd1_op_i),
        .upd_ready_o(upd_ready_o), .hold_i(hold_i), .flush_i(flush_i),
        .btb_fixwe_o(btb_fixwe_o), .btb_fixpc_o(btb_fixpc_o),
        .btb_fixjumpaddr_o(btb_fixjumpaddr_o), .btb_fixjumpop_o(btb_fixjumpop_o),
        .btb_inv_o(btb_inv_o), .btb_inv_idx_o(btb_inv_idx_o),
        .sweep_busy_o(sweep_busy_o), .overflow_o(overflow_o)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] tgt;
        logic [2:0]  op;
    } ent_t;

    ent_t        mq[$];
    bit          m_sweep;
    int          m_idx;
    bit          m_ovf;
    bit          m_fixwe;
    logic [63:0] m_fpc, m_ftgt;
    logic [2:0]  m_fop;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_req(input logic [63:0] pc, input logic [63:0] tgt, input logic [2:0] op);
        ent_t e;
        bit   found = 0;
        foreach (mq[i]) begin
            if (mq[i].pc == pc) begin
                e = mq[i];
                e.tgt = tgt;
                e.op = op;
                mq[i] = e;
                found = 1;
            end
        end
        if (!found) begin
            if (mq.size() < QD) begin
                e.pc = pc;
                e.tgt = tgt;
                e.op = op;
                mq.push_back(e);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic model_step();
        ent_t h;
        if (rst) begin
            mq.delete();
            m_sweep = 0; m_idx = 0; m_ovf = 0; m_fixwe = 0;
            m_fpc = '0; m_ftgt = '0; m_fop = '0;
            return;
        end
        m_fixwe = 0;
        if (flush_i) begin
            mq.delete();
            m_sweep = 1;
            m_idx = 0;
        end else if (m_sweep) begin
            if (m_idx == N - 1) m_sweep = 0;
            else m_idx++;
        end else begin
            if (mq.size() > 0 && !hold_i) begin
                h = mq.pop_front();
                m_fixwe = 1;
                m_fpc = h.pc; m_ftgt = h.tgt; m_fop = h.op;
            end
            if (upd0_valid_i && upd1_valid_i && upd0_pc_i == upd1_pc_i) begin
                model_req(upd1_pc_i, upd1_target_i, upd1_op_i);
            end else begin
                if (upd0_valid_i) model_req(upd0_pc_i, upd0_target_i, upd0_op_i);
                if (upd1_valid_i) model_req(upd1_pc_i, upd1_target_i, upd1_op_i);
            end
        end
    endtask

    task automatic check_outputs();
        chk("fixwe", 64'(btb_fixwe_o), 64'(m_fixwe));
        chk("fixpc", btb_fixpc_o, m_fpc);
        chk("fixtgt", btb_fixjumpaddr_o, m_ftgt);
        chk("fixop", 64'(btb_fixjumpop_o), 64'(m_fop));
        chk("inv", 64'(btb_inv_o), 64'(m_sweep));
        if (m_sweep) chk("inv_idx", 64'(btb_inv_idx_o), 64'(m_idx));
        chk("busy", 64'(sweep_busy_o), 64'(m_sweep));
        chk("ready", 64'(upd_ready_o), 64'(!m_sweep && mq.size() <= QD - 2));
        chk("ovf", 64'(overflow_o), 64'(m_ovf));
    endtask

    task automatic step(input bit r, input bit fl, input bit hd,
                        input bit v0, input logic [63:0] p0, input logic [63:0] t0, input logic [2:0] o0,
                        input bit v1, input logic [63:0] p1, input logic [63:0] t1, input logic [2:0] o1);
        rst = r; flush_i = fl; hold_i = hd;
        upd0_valid_i = v0; upd0_pc_i = p0; upd0_target_i = t0; upd0_op_i = o0;
        upd1_valid_i = v1; upd1_pc_i = p1; upd1_target_i = t1; upd1_op_i = o1;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic nop(input int n, input bit hd);
        for (int k = 0; k < n; k++) step(0, 0, hd, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [63:0] rpc();
        return 64'h8000_0000 + 64'(4 * $urandom_range(0, 7));
    endfunction

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // single update
        step(0, 0, 0, 1, 64'h8000_0010, 64'h8000_0100, 3'd3, 0, 0, 0, 0);
        nop(3, 0);

        // dual same-pc update under hold, then release
        step(0, 0, 1, 1, 64'h8000_0020, 64'hA0, 3'd1, 1, 64'h8000_0020, 64'hB0, 3'd2);
        nop(2, 1);
        nop(3, 0);

        // fill and backpressure
        step(0, 0, 1, 1, 64'h100, 64'h1100, 3'd1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 64'h104, 64'h1104, 3'd2, 0, 0, 0, 0);
        step(0, 0, 1, 1, 64'h108, 64'h1108, 3'd3, 0, 0, 0, 0);
        step(0, 0, 1, 1, 64'h10C, 64'h110C, 3'd4, 1, 64'h110, 64'h1110, 3'd5);
        nop(6, 0);

        // enqueue while draining
        for (int k = 0; k < 10; k++)
            step(0, 0, 0, 1, 64'h200 + 64'(4 * k), 64'h3000 + 64'(k), 3'(k), 0, 0, 0, 0);
        nop(2, 0);

        // flush with pending entries, full sweep
        step(0, 0, 1, 1, 64'h300, 64'h1, 3'd1, 1, 64'h304, 64'h2, 3'd2);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(N + 4, 0);

        // restart mid-sweep, then reset mid-sweep
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(100, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(N + 4, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(50, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(3, 0);

        // random traffic with a small pc pool to provoke coalescing and overflow
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0), rpc(), {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0), rpc(), {$urandom, $urandom}, 3'($urandom_range(0, 7)));
        end
        nop(N + 4, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
